// File: rtl/universal_register.sv
// Universal shift/rotate/count register: parallel load plus multi-step shift,
// rotate, increment and decrement, one step per clock, with busy/done handshake.
module universal_register #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amount,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   localparam logic [2:0] ModeHold = 3'd0;
   localparam logic [2:0] ModeLoad = 3'd1;
   localparam logic [2:0] ModeShl  = 3'd2;
   localparam logic [2:0] ModeShr  = 3'd3;
   localparam logic [2:0] ModeRotl = 3'd4;
   localparam logic [2:0] ModeRotr = 3'd5;
   localparam logic [2:0] ModeInc  = 3'd6;
   localparam logic [2:0] ModeDec  = 3'd7;

   state_e           state_q;
   logic [2:0]       mode_q;
   logic [AMT_W-1:0] cnt_q;
   logic [WIDTH-1:0] q_q;
   logic             sout_q;
   logic             busy_q;
   logic             done_q;

   logic [2:0]       step_mode;
   logic [WIDTH-1:0] step_val;
   logic             step_bit;

   // In IDLE the step uses the incoming mode so step 1 happens on the start edge.
   assign step_mode = (state_q == StRun) ? mode_q : mode;

   always_comb begin
      step_val = q_q;
      step_bit = sout_q;
      case (step_mode)
         ModeShl: begin
            step_val = {q_q[WIDTH-2:0], sin};
            step_bit = q_q[WIDTH-1];
         end
         ModeShr: begin
            step_val = {sin, q_q[WIDTH-1:1]};
            step_bit = q_q[0];
         end
         ModeRotl: begin
            step_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            step_bit = q_q[WIDTH-1];
         end
         ModeRotr: begin
            step_val = {q_q[0], q_q[WIDTH-1:1]};
            step_bit = q_q[0];
         end
         ModeInc: begin
            {step_bit, step_val} = {1'b0, q_q} + (WIDTH + 1)'(1);
         end
         ModeDec: begin
            step_val = q_q - WIDTH'(1);
            step_bit = (q_q == '0);
         end
         default: begin
            step_val = q_q;
            step_bit = sout_q;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         mode_q  <= ModeHold;
         cnt_q   <= '0;
         q_q     <= '0;
         sout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  mode_q <= mode;
                  cnt_q  <= amount;
                  if (mode == ModeLoad) begin
                     q_q    <= d;
                     sout_q <= 1'b0;
                     done_q <= 1'b1;
                  end else if (mode == ModeHold || amount == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     q_q    <= step_val;
                     sout_q <= step_bit;
                     cnt_q  <= amount - AMT_W'(1);
                     if (amount == AMT_W'(1)) begin
                        done_q <= 1'b1;
                     end else begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                     end
                  end
               end
            end
            StRun: begin
               q_q    <= step_val;
               sout_q <= step_bit;
               if (cnt_q == AMT_W'(1)) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
               cnt_q <= cnt_q - AMT_W'(1);
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign q    = q_q;
   assign sout = sout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_universal_register.sv
// Directed bench for universal_register: vector table of chained operations
// plus hand sequences for back-to-back start, ignored start and mid-run reset.
module tb_universal_register;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] mode;
   logic [3:0] amount;
   logic [7:0] d;
   logic       sin;
   logic [7:0] q;
   logic       sout;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;

   universal_register #(.WIDTH(8), .AMT_W(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .mode   (mode),
      .amount (amount),
      .d      (d),
      .sin    (sin),
      .q      (q),
      .sout   (sout),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] mode;
      logic [3:0] amt;
      logic [7:0] d;
      logic       sin;
      logic [7:0] eq;
      logic       es;
      int         eedges;
      int         ebusy;
      string      name;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one start, then wait (bounded) for done; returns edges taken and busy cycles.
   task automatic run_op(input vec_t v, output int edges, output int busy_cnt);
      @(negedge clk);
      start  = 1'b1;
      mode   = v.mode;
      amount = v.amt;
      d      = v.d;
      sin    = v.sin;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      edges    = 1;
      busy_cnt = 0;
      while (done !== 1'b1 && edges < 40) begin
         if (busy === 1'b1) busy_cnt++;
         chk({v.name, " busy&done"}, 32'(busy & done), 32'd0);
         @(posedge clk);
         @(negedge clk);
         edges++;
      end
      chk({v.name, " busy at done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int e;
      int b;
      int seen_done;

      vecs[0]  = '{3'd1, 4'd0, 8'hA5, 1'b0, 8'hA5, 1'b0, 1, 0, "load A5"};
      vecs[1]  = '{3'd4, 4'd3, 8'h00, 1'b0, 8'h2D, 1'b1, 3, 2, "rotl x3"};
      vecs[2]  = '{3'd1, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1, 0, "load 00"};
      vecs[3]  = '{3'd3, 4'd8, 8'h00, 1'b1, 8'hFF, 1'b0, 8, 7, "shr x8 sin1"};
      vecs[4]  = '{3'd6, 4'd1, 8'h00, 1'b0, 8'h00, 1'b1, 1, 0, "inc wrap"};
      vecs[5]  = '{3'd7, 4'd2, 8'h00, 1'b0, 8'hFE, 1'b0, 2, 1, "dec x2 wrap"};
      vecs[6]  = '{3'd1, 4'd0, 8'h9E, 1'b0, 8'h9E, 1'b0, 1, 0, "load 9E"};
      vecs[7]  = '{3'd2, 4'd1, 8'h00, 1'b0, 8'h3C, 1'b1, 1, 0, "shl x1"};
      vecs[8]  = '{3'd0, 4'd5, 8'h00, 1'b0, 8'h3C, 1'b1, 1, 0, "hold"};
      vecs[9]  = '{3'd2, 4'd0, 8'h00, 1'b1, 8'h3C, 1'b1, 1, 0, "shl x0"};
      vecs[10] = '{3'd1, 4'd7, 8'h00, 1'b0, 8'h00, 1'b0, 1, 0, "load ign amt"};
      vecs[11] = '{3'd7, 4'd1, 8'h00, 1'b0, 8'hFF, 1'b1, 1, 0, "dec borrow"};
      vecs[12] = '{3'd5, 4'd0, 8'h00, 1'b0, 8'hFF, 1'b1, 1, 0, "rotr x0"};
      vecs[13] = '{3'd6, 4'd3, 8'h00, 1'b0, 8'h02, 1'b0, 3, 2, "inc x3"};
      vecs[14] = '{3'd5, 4'd5, 8'h00, 1'b0, 8'h10, 1'b0, 5, 4, "rotr x5"};

      reset  = 1'b1;
      start  = 1'b0;
      mode   = 3'd0;
      amount = 4'd0;
      d      = 8'h00;
      sin    = 1'b0;
      #12;
      chk("reset q", 32'(q), 32'h00);
      chk("reset sout", 32'(sout), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         run_op(vecs[i], e, b);
         chk({vecs[i].name, " q"}, 32'(q), 32'(vecs[i].eq));
         chk({vecs[i].name, " sout"}, 32'(sout), 32'(vecs[i].es));
         chk({vecs[i].name, " edges"}, 32'(e), 32'(vecs[i].eedges));
         chk({vecs[i].name, " busy cycles"}, 32'(b), 32'(vecs[i].ebusy));
      end

      // Back-to-back: new start accepted in the done cycle, done lasts one cycle.
      @(negedge clk);
      start = 1'b1; mode = 3'd1; d = 8'hA5; amount = 4'd0;
      @(posedge clk);
      @(negedge clk);
      chk("b2b load done", 32'(done), 32'd1);
      chk("b2b load q", 32'(q), 32'hA5);
      mode = 3'd4; amount = 4'd1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("b2b rotl q", 32'(q), 32'h4B);
      chk("b2b rotl sout", 32'(sout), 32'd1);
      chk("b2b rotl done", 32'(done), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("done one cycle", 32'(done), 32'd0);

      // rotr x10 from A5: start at step 3 ignored, reset at step 5 aborts.
      start = 1'b1; mode = 3'd1; d = 8'hA5;
      @(posedge clk);
      @(negedge clk);
      mode = 3'd5; amount = 4'd10;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("rotr step1", 32'(q), 32'hD2);
      @(posedge clk);
      @(negedge clk);
      chk("rotr step2", 32'(q), 32'h69);
      start = 1'b1; mode = 3'd1; d = 8'h00;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("ignored start q", 32'(q), 32'hB4);
      chk("ignored start busy", 32'(busy), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("rotr step4", 32'(q), 32'h5A);
      #1 reset = 1'b1;
      #1;
      chk("async reset q", 32'(q), 32'h00);
      chk("async reset busy", 32'(busy), 32'd0);
      chk("async reset sout", 32'(sout), 32'd0);
      #1 reset = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen_done++;
      end
      chk("no done after abort", 32'(seen_done), 32'd0);
      chk("idle after abort", 32'(busy), 32'd0);

      // First start after reset is accepted.
      start = 1'b1; mode = 3'd1; d = 8'h55;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("post-reset load q", 32'(q), 32'h55);
      chk("post-reset load done", 32'(done), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/universal_register.md
UNIVERSAL_REGISTER -- requirements
Module: universal_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: register width in bits, minimum 2.
REQ-002 The block SHALL have parameter AMT_W, default 4: width of the step-count input.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, named clk and reset as elsewhere in the codebase.
REQ-004 The port list SHALL be:
- clk  input  1: clock; all state updates on the rising edge.
- reset  input  1: asynchronous, active-high reset.
- start  input  1: request an operation; sampled on the rising edge.
- mode  input  3: operation code, captured at start.
- amount  input  AMT_W: step count, captured at start.
- d  input  WIDTH: parallel load data, sampled only at start.
- sin  input  1: serial fill bit, sampled at every shift step.
- q  output  WIDTH: register contents.
- sout  output  1: bit shifted out, or carry/borrow, of the last step.
- busy  output  1: multi-cycle operation in progress.
- done  output  1: one-cycle completion pulse.

Function
REQ-005 The mode encoding SHALL be:
- 0 hold
- 1 load
- 2 shl: q <= {q[W-2:0], sin}
- 3 shr: q <= {sin, q[W-1:1]}
- 4 rotl
- 5 rotr
- 6 inc (+1)
- 7 dec (-1)
REQ-006 The state machine SHALL have two states, IDLE and RUN; busy SHALL be 1 exactly in RUN.
REQ-007 In IDLE, start=1 SHALL latch mode and amount; any start while busy=1 SHALL be ignored.
REQ-008 Load SHALL set q <= d on the start edge (E0), then done=1 for the next cycle and sout=0; it SHALL stay in IDLE and ignore amount.
REQ-009 Hold, or any step mode with amount=0, SHALL leave q and sout unchanged and pulse done=1 after E0.
REQ-010 A step mode with amount=N>=1 SHALL perform step 1 at E0 and one further step per edge at E1..E(N-1): exactly N steps.
REQ-011 If N>1, the block SHALL enter RUN at E0 and return to IDLE at E(N-1).
REQ-012 done SHALL be high for the single cycle after E(N-1); done and busy SHALL never both be 1.
REQ-013 A remaining-step counter SHALL decrement once per step; exit from RUN SHALL be taken when its value is 1 at an edge.
REQ-014 sout SHALL be updated on every step, taken from the pre-step value of q:
- shl and rotl: q[W-1]
- shr and rotr: q[0]
- inc: carry-out (1 when q wraps from all-ones to 0)
- dec: borrow (1 when q wraps from 0 to all-ones)
REQ-015 sout SHALL otherwise hold its value.
REQ-016 inc and dec SHALL wrap modulo 2^WIDTH.
REQ-017 A new start SHALL be accepted in the same cycle that done=1, giving back-to-back operations with no idle gap.
REQ-018 The outputs q, sout, busy and done SHALL all be registered.

Reset
REQ-019 reset=1 SHALL immediately, without a clock edge, force q=0, sout=0, busy=0, done=0, state=IDLE and clear the latched mode and amount.
REQ-020 Reset mid-operation SHALL abort it with no done pulse.
REQ-021 After reset is released, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8, AMT_W=4)
REQ-022 Reset, then start, mode=1, d=0xA5 -> after 1 edge q=0xA5, done=1 for one cycle, busy stays 0, sout=0.
REQ-023 From q=0xA5, start, mode=4, amount=3 -> q goes 0x4B, 0x96, 0x2D on successive edges; busy=1 for 2 cycles; done=1 the cycle after the third edge; sout=1.
REQ-024 From q=0x00, mode=3, amount=8, sin=1 -> q=0xFF after 8 edges; busy=1 for 7 cycles; sout=0.
REQ-025 Increment and decrement wrap:
- From q=0xFF, mode=6, amount=1 -> q=0x00, sout=1, done after 1 edge, busy never 1.
- From q=0x00, mode=7, amount=2 -> q=0xFE, sout=0.
REQ-026 During a mode=5, amount=10 operation:
- start with mode=1 at step 3 -> ignored; q continues rotating.
- reset pulsed at step 5 -> q=0 and busy=0 asynchronously, and done never pulses.
REQ-027 From q=0x3C, mode=0 or mode=2 with amount=0 -> q=0x3C unchanged, sout unchanged, done pulse after 1 edge.
